roberto_receptor_uc: RTL
========================

Name: roberto_receptor_uc

Overview:
- Peer-side counterpart of the measurement/serial-transmit control unit.
- Collects the sensor frame arriving byte-by-byte from a UART receiver: N_SENSORES x BYTES_SENSOR bytes, in order.
- Buffers the frame and flags completion, then waits for a response from the consumer logic.
- Sends the N_RESP response bytes back through a UART transmitter with a start/done handshake, so the remote unit's reception phase completes.

Parameters:
- N_SENSORES, 2, sensors per frame
- BYTES_SENSOR, 4, bytes per sensor reading
- N_RESP, 3, response bytes returned per frame
- TIMEOUT, 50000000, max clock cycles between consecutive received bytes once a frame has started

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- habilita  in  1  arms reception of one frame (sampled in ocioso only)
- rx_pronto  in  1  one-cycle pulse: rx_dado holds a new byte
- rx_dado  in  8  received byte
- tx_pronto  in  1  one-cycle pulse: transmitter finished current byte
- resp_valido  in  1  response available (level or pulse)
- resp_dado  in  8*N_RESP  response bytes, byte 0 in bits [7:0], sent first
- tx_partida  out  1  one-cycle start pulse to transmitter
- tx_dado  out  8  byte to transmit, held stable until tx_pronto
- medidas  out  8*N_SENSORES*BYTES_SENSOR  frame buffer, byte k (k-th received) in bits [8k+7:8k]
- quadro_pronto  out  1  one-cycle pulse: full frame stored
- erro_timeout  out  1  one-cycle pulse: frame aborted by inter-byte timeout
- ocupado  out  1  high in every state except ocioso
- db_estado  out  4  current state code

Behaviour:
- Reset: state ocioso; medidas, tx_dado, byte index, response index, timeout counter, response register = 0; all pulse outputs 0.
- TOTAL = N_SENSORES*BYTES_SENSOR. Index widths = $clog2 of the respective count (minimum 1). The timeout counter is wide enough for TIMEOUT.
- States (db_estado):
  - ocioso (0): clears byte index and timeout counter. habilita=1 -> espera_byte. rx_pronto ignored.
  - espera_byte (1), rx_pronto=1:
    - writes rx_dado to medidas slot idx on that edge and clears the timeout counter.
    - idx==TOTAL-1 -> quadro_ok; otherwise idx+1, stay.
  - espera_byte (1), no rx_pronto:
    - idx==0: wait indefinitely, counter held at 0.
    - idx>0: counter increments. Reaching TIMEOUT-1 with no byte -> erro (TIMEOUT cycles after the last byte).
    - rx_pronto on the threshold cycle: byte wins, no error.
  - quadro_ok (2): quadro_pronto=1 for exactly one cycle -> espera_resp.
  - espera_resp (3): on resp_valido=1, latch resp_dado, clear response index j -> envia.
  - envia (4): tx_partida=1 for one cycle; tx_dado = response byte j (registered, valid the same cycle) -> espera_tx.
  - espera_tx (5): tx_dado held. On tx_pronto: j==N_RESP-1 -> fim; otherwise j+1 -> envia.
  - fim (6): one cycle -> ocioso.
  - erro (7): erro_timeout=1 for one cycle -> ocioso.
- medidas holds its last contents after fim or erro; an aborted frame leaves partial new bytes in place. Slots are overwritten only by the next frame.
- habilita is ignored outside ocioso; deasserting it mid-frame does not abort.
- Ignored inputs:
  - rx_pronto outside espera_byte is dropped.
  - tx_pronto outside espera_tx is ignored.
  - resp_valido outside espera_resp is ignored.
  - The latched response is unaffected by later resp_dado changes.
- Reset asserted in any state returns everything to reset values on that edge, including mid-transmit. tx_partida is never re-issued after reset.
- Unused state encodings -> ocioso.
- Latency:
  - Last byte rx_pronto edge -> quadro_pronto high next cycle.
  - resp_valido edge -> tx_partida high next cycle.
  - tx_pronto of byte j -> tx_partida for byte j+1 next cycle.

Test Plan:
- Normal frame: habilita, send bytes 0x30..0x37 with 5-cycle gaps -> medidas = 0x3736353433323130; single quadro_pronto one cycle after the 8th byte; db_estado 1 -> 2 -> 3.
- Response: resp_valido with resp_dado=0x0A4231 -> tx_partida pulses 3 times with tx_dado 0x31, 0x42, 0x0A, each after tx_pronto. fim then ocioso; ocupado drops; exactly 3 tx_partida total.
- Timeout (TIMEOUT=20): 3 bytes, then silence -> erro_timeout pulses exactly 20 cycles after the 3rd rx_pronto; returns to ocioso; no quadro_pronto; medidas low 3 bytes updated.
- Boundary: rx_pronto on the threshold cycle -> no error, byte stored. Idle espera_byte with idx=0 for 1000 cycles -> no timeout.
- Spurious inputs: rx_pronto in ocioso/espera_resp, and tx_pronto in espera_resp -> no state change, medidas unchanged.
- Reset mid-transmit (during espera_tx of byte 1) -> next cycle db_estado=0, tx_dado=0, medidas=0, no further tx_partida.

Source files
------------

// File: rtl/roberto_receptor_uc.sv
// Receive-side control unit: gathers a sensor frame byte by byte from a UART receiver,
// flags completion, then returns N_RESP response bytes through a UART transmitter.
module roberto_receptor_uc #(
  parameter int unsigned N_SENSORES   = 2,
  parameter int unsigned BYTES_SENSOR = 4,
  parameter int unsigned N_RESP       = 3,
  parameter int unsigned TIMEOUT      = 50000000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  habilita,
  input  logic                                  rx_pronto,
  input  logic [7:0]                            rx_dado,
  input  logic                                  tx_pronto,
  input  logic                                  resp_valido,
  input  logic [8*N_RESP-1:0]                   resp_dado,
  output logic                                  tx_partida,
  output logic [7:0]                            tx_dado,
  output logic [8*N_SENSORES*BYTES_SENSOR-1:0]  medidas,
  output logic                                  quadro_pronto,
  output logic                                  erro_timeout,
  output logic                                  ocupado,
  output logic [3:0]                            db_estado
);

  localparam int unsigned TOTAL = N_SENSORES * BYTES_SENSOR;
  localparam int unsigned IDXW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned JW    = (N_RESP > 1) ? $clog2(N_RESP) : 1;
  localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);
  localparam logic [JW-1:0]   LAST_J   = JW'(N_RESP - 1);
  localparam logic [CW-1:0]   CNT_LIM  = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    ESPERA_BYTE = 4'd1,
    QUADRO_OK   = 4'd2,
    ESPERA_RESP = 4'd3,
    ENVIA       = 4'd4,
    ESPERA_TX   = 4'd5,
    FIM         = 4'd6,
    ERRO        = 4'd7
  } estado_t;

  estado_t                         state_q, state_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic [JW-1:0]                   j_q, j_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [8*N_RESP-1:0]             resp_q, resp_d;
  logic [7:0]                      txd_q, txd_d;
  logic [8*TOTAL-1:0]              med_q, med_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      idx_q   <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      txd_q   <= '0;
      med_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      txd_q   <= txd_d;
      med_q   <= med_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    j_d           = j_q;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    txd_d         = txd_q;
    med_d         = med_q;
    tx_partida    = 1'b0;
    quadro_pronto = 1'b0;
    erro_timeout  = 1'b0;
    case (state_q)
      OCIOSO: begin
        idx_d = '0;
        cnt_d = '0;
        if (habilita) state_d = ESPERA_BYTE;
      end
      ESPERA_BYTE: begin
        if (rx_pronto) begin
          med_d[8*idx_q +: 8] = rx_dado;
          cnt_d = '0;
          if (idx_q == LAST_IDX) state_d = QUADRO_OK;
          else                   idx_d   = idx_q + IDXW'(1);
        end else if (idx_q != '0) begin
          // An arriving byte on the threshold cycle takes priority over the timeout.
          if (cnt_q == CNT_LIM) state_d = ERRO;
          else                  cnt_d   = cnt_q + CW'(1);
        end
      end
      QUADRO_OK: begin
        quadro_pronto = 1'b1;
        state_d       = ESPERA_RESP;
      end
      ESPERA_RESP: begin
        if (resp_valido) begin
          resp_d  = resp_dado;
          j_d     = '0;
          txd_d   = resp_dado[7:0];
          state_d = ENVIA;
        end
      end
      ENVIA: begin
        tx_partida = 1'b1;
        state_d    = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (tx_pronto) begin
          if (j_q == LAST_J) begin
            state_d = FIM;
          end else begin
            j_d     = j_q + JW'(1);
            txd_d   = resp_q[8*j_d +: 8];
            state_d = ENVIA;
          end
        end
      end
      FIM:     state_d = OCIOSO;
      ERRO: begin
        erro_timeout = 1'b1;
        state_d      = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  assign tx_dado   = txd_q;
  assign medidas   = med_q;
  assign ocupado   = (state_q != OCIOSO);
  assign db_estado = state_q;

endmodule
